// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: run/single-step control, load-use stall,
// branch flush, HALT drain, plus advancing-cycle and stall counters.
module pipe_ctrl #(
  parameter int W         = 5,
  parameter int DRAIN_CYC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step_mode,
  input  logic         step,
  input  logic         halt_id,
  input  logic [W-1:0] ifid_rs,
  input  logic [W-1:0] ifid_rt,
  input  logic [W-1:0] idex_rt,
  input  logic         idex_mem_read,
  input  logic         branch_taken,
  output logic         pc_ena,
  output logic         ifid_ena,
  output logic         idex_ena,
  output logic         exmem_ena,
  output logic         memwb_ena,
  output logic         ifid_flush,
  output logic         idex_flush,
  output logic         halted,
  output logic [31:0]  cycle_count,
  output logic [15:0]  stall_count
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          active, hazard, stall, halt_go;

  assign active  = (state == RUN) || (state == STEP_EXEC);
  assign hazard  = idex_mem_read && (idex_rt != '0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  // A taken branch flushes both the hazard consumer and any HALT in ID
  assign stall   = active && hazard && !branch_taken;
  assign halt_go = active && halt_id && !branch_taken;

  always_comb begin
    pc_ena     = 1'b0;
    ifid_ena   = 1'b0;
    idex_ena   = 1'b0;
    exmem_ena  = 1'b0;
    memwb_ena  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state)
      RUN, STEP_EXEC: begin
        pc_ena    = 1'b1;
        ifid_ena  = 1'b1;
        idex_ena  = 1'b1;
        exmem_ena = 1'b1;
        memwb_ena = 1'b1;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (hazard) begin
          pc_ena     = 1'b0;
          ifid_ena   = 1'b0;
          idex_flush = 1'b1;
        end
      end
      DRAIN: begin
        idex_ena   = 1'b1;
        idex_flush = 1'b1;
        exmem_ena  = 1'b1;
        memwb_ena  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (active || state == DRAIN) cycle_count <= cycle_count + 32'd1;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      case (state)
        IDLE:      if (start) state <= step_mode ? STEP_WAIT : RUN;
        RUN: if (halt_go) begin
          state     <= DRAIN;
          drain_cnt <= CW'(DRAIN_CYC - 1);
        end
        STEP_WAIT: if (step) state <= STEP_EXEC;
        STEP_EXEC: if (halt_go) begin
          state     <= DRAIN;
          drain_cnt <= CW'(DRAIN_CYC - 1);
        end else begin
          state <= STEP_WAIT;
        end
        DRAIN: if (drain_cnt == '0) begin
          state  <= DONE;
          halted <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        DONE:      halted <= 1'b1;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// sessions checked against a phase-level reference model.
module tb_pipe_ctrl;
  localparam int W = 5;
  localparam int DRAIN_CYC = 4;

  logic         clk = 1'b0;
  logic         reset, start, step_mode, step, halt_id;
  logic [W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic         idex_mem_read, branch_taken;
  logic         pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
  logic         ifid_flush, idex_flush, halted;
  logic [31:0]  cycle_count;
  logic [15:0]  stall_count;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.W(W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .halt_id(halt_id), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
    .idex_mem_read(idex_mem_read), .branch_taken(branch_taken),
    .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena),
    .exmem_ena(exmem_ena), .memwb_ena(memwb_ena), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted), .cycle_count(cycle_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena, ifid_flush, idex_flush};

  // Reference model: program phase tracked as started/stepping/drain-remaining/halted
  bit          m_started, m_stepmode, m_exec_now, m_halted;
  int          m_drain;
  int unsigned m_cyc, m_stall;

  function automatic void model_reset();
    m_started = 0; m_stepmode = 0; m_exec_now = 0; m_halted = 0;
    m_drain = 0; m_cyc = 0; m_stall = 0;
  endfunction

  function automatic bit hz();
    return idex_mem_read && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  function automatic bit executing();
    return m_started && !m_halted && m_drain == 0 && (!m_stepmode || m_exec_now);
  endfunction

  function automatic logic [6:0] exp_outs();
    if (!m_started || m_halted) return 7'b0000000;
    if (m_drain > 0)            return 7'b0011101;
    if (!executing())           return 7'b0000000;
    if (branch_taken)           return 7'b1111111;
    if (hz())                   return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic tick();
    if (!reset) model_reset();
    else if (!m_started) begin
      if (start) begin m_started = 1; m_stepmode = step_mode; end
    end else if (m_halted) begin
    end else if (m_drain > 0) begin
      m_cyc++; m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (executing()) begin
      m_cyc++;
      if (hz() && !branch_taken && m_stall < 65535) m_stall++;
      m_exec_now = 0;
      if (halt_id && !branch_taken) m_drain = DRAIN_CYC;
    end else if (step) m_exec_now = 1;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step = 0; halt_id = 0; ifid_rs = 0; ifid_rt = 0;
    idex_rt = 0; idex_mem_read = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    reset = 0; model_reset(); tick(); tick(); reset = 1;
  endtask

  task automatic launch(input bit sm);
    start = 1; step_mode = sm; tick(); start = 0; step_mode = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 0; model_reset(); #3;
    n_cmp++; if (outs !== 7'b0 || halted !== 1'b0) begin
      n_err++; $display("FAIL reset_outs: got %b/%b want 0000000/0", outs, halted); end
    n_cmp++; if (cycle_count !== 32'd0 || stall_count !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_count, stall_count); end
    tick(); reset = 1; tick();
    @(negedge clk);
    n_cmp++; if (outs !== 7'b0) begin
      n_err++; $display("FAIL idle_outs: got %b want 0000000", outs); end
  endtask

  task automatic test_run();
    launch(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (outs !== 7'b1111100) begin
        n_err++; $display("FAIL run_ena[%0d]: got %b want 1111100", i, outs); end
      tick();
    end
    n_cmp++; if (cycle_count !== 32'd10) begin
      n_err++; $display("FAIL run_cycles: got %0d want 10", cycle_count); end
  endtask

  task automatic test_load_use();
    idex_mem_read = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 9;
    @(negedge clk);
    n_cmp++; if (outs !== 7'b0011101) begin
      n_err++; $display("FAIL hazard_outs: got %b want 0011101", outs); end
    tick();
    n_cmp++; if (stall_count !== 16'd1) begin
      n_err++; $display("FAIL hazard_stall: got %0d want 1", stall_count); end
    idex_rt = 0; ifid_rs = 0;
    @(negedge clk);
    n_cmp++; if (outs !== 7'b1111100) begin
      n_err++; $display("FAIL r0_outs: got %b want 1111100", outs); end
    tick();
    n_cmp++; if (stall_count !== 16'd1) begin
      n_err++; $display("FAIL r0_stall: got %0d want 1", stall_count); end
  endtask

  task automatic test_branch_priority();
    idex_mem_read = 1; idex_rt = 5; ifid_rs = 5; branch_taken = 1;
    @(negedge clk);
    n_cmp++; if (outs !== 7'b1111111) begin
      n_err++; $display("FAIL branch_outs: got %b want 1111111", outs); end
    tick(); clear_inputs();
    n_cmp++; if (stall_count !== 16'd1) begin
      n_err++; $display("FAIL branch_stall: got %0d want 1", stall_count); end
  endtask

  task automatic test_step();
    int n = 0;
    do_reset(); launch(1);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk); if (pc_ena === 1'b1) n++;
        tick();
      end
      step = 1; @(negedge clk); if (pc_ena === 1'b1) n++;
      tick(); step = 0;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); if (pc_ena === 1'b1) n++;
      tick();
    end
    n_cmp++; if (n != 3) begin
      n_err++; $display("FAIL step_ena_cycles: got %0d want 3", n); end
    n_cmp++; if (cycle_count !== 32'd3) begin
      n_err++; $display("FAIL step_cycles: got %0d want 3", cycle_count); end
  endtask

  task automatic test_halt();
    int n = 0;
    do_reset(); launch(0);
    halt_id = 1; tick(); halt_id = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
      if (outs === 7'b0011101) n++;
      tick();
    end
    n_cmp++; if (n != DRAIN_CYC) begin
      n_err++; $display("FAIL drain_len: got %0d want %0d", n, DRAIN_CYC); end
    n_cmp++; if (halted !== 1'b1 || outs !== 7'b0) begin
      n_err++; $display("FAIL done_state: got %b/%b want 1/0000000", halted, outs); end
    launch(0); tick(); tick();
    @(negedge clk);
    n_cmp++; if (halted !== 1'b1 || outs !== 7'b0 || cycle_count !== 32'd5) begin
      n_err++; $display("FAIL done_start: got %b/%b/%0d want 1/0000000/5", halted, outs, cycle_count); end
  endtask

  task automatic test_reset_in_drain();
    bit saw_halt = 0;
    do_reset(); launch(0);
    halt_id = 1; tick(); halt_id = 0; tick(); tick();
    #2 reset = 0; model_reset(); #1;
    n_cmp++; if (outs !== 7'b0 || cycle_count !== 32'd0 || halted !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got %b/%0d/%b want 0000000/0/0", outs, cycle_count, halted); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (halted) saw_halt = 1; tick(); end
    reset = 1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (halted || outs != 0) saw_halt = 1; tick(); end
    n_cmp++; if (saw_halt) begin
      n_err++; $display("FAIL reset_abort: got activity after reset want idle"); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      clear_inputs(); do_reset();
      for (int i = 0; i < 150; i++) begin
        start = ($urandom % 8) == 0; step_mode = $urandom % 2; step = ($urandom % 3) == 0;
        halt_id = ($urandom % 40) == 0; branch_taken = ($urandom % 5) == 0;
        idex_mem_read = $urandom % 2; idex_rt = W'($urandom % 4);
        ifid_rs = W'($urandom % 4); ifid_rt = W'($urandom % 4);
        @(negedge clk);
        n_cmp++; if (outs !== exp_outs() || halted !== m_halted) begin
          n_err++; $display("FAIL rand_outs s%0d c%0d: got %b/%b want %b/%b", s, i, outs, halted, exp_outs(), m_halted); end
        n_cmp++; if (cycle_count !== m_cyc || stall_count !== 16'(m_stall)) begin
          n_err++; $display("FAIL rand_cnt s%0d c%0d: got %0d/%0d want %0d/%0d", s, i, cycle_count, stall_count, m_cyc, m_stall); end
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_branch_priority();
    test_step();
    test_halt();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter W, default 5: register-specifier width.
REQ-002 Parameter DRAIN_CYC, default 4: cycles allowed for in-flight instructions to retire after HALT.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; leaves IDLE.
REQ-006 step_mode  in  1  sampled with start: 0 = continuous run, 1 = single-step.
REQ-007 step  in  1  one-cycle pulse; advances the pipeline one cycle in step mode.
REQ-008 halt_id  in  1  HALT opcode present in ID stage.
REQ-009 ifid_rs, ifid_rt  in  W each  source registers of the instruction in ID.
REQ-010 idex_rt  in  W  destination register of the instruction held in the ID/EX stage register.
REQ-011 idex_mem_read  in  1  ID/EX instruction is a load.
REQ-012 branch_taken  in  1  taken branch or jump resolved this cycle.
REQ-013 pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena  out  1 each  stage-register enables.
REQ-014 ifid_flush, idex_flush  out  1 each  flush requests; flush is honoured only while the matching ena is 1.
REQ-015 halted  out  1  program complete, pipeline frozen.
REQ-016 cycle_count  out  32  advancing-cycle counter.
REQ-017 stall_count  out  16  load-use stall counter.

Function
REQ-018 FSM states SHALL be IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, DONE.
REQ-019 IDLE: all ena and flush outputs 0; start with step_mode=0 -> RUN; start with step_mode=1 -> STEP_WAIT.
REQ-020 STEP_WAIT: all ena 0; step -> STEP_EXEC.
REQ-021 STEP_EXEC lasts exactly one cycle with RUN output rules, then -> STEP_WAIT.
REQ-022 RUN/STEP_EXEC base outputs: all five ena = 1, both flush = 0.
REQ-023 Load-use hazard is idex_mem_read=1 AND idex_rt!=0 AND (idex_rt==ifid_rs OR idex_rt==ifid_rt).
REQ-024 On a load-use hazard: pc_ena=0, ifid_ena=0, idex_ena=1, idex_flush=1 (one bubble); the remaining enables stay 1.
REQ-025 On branch_taken: ifid_flush=1, idex_flush=1, all ena=1; branch_taken SHALL take priority over a simultaneous load-use hazard, and no stall is counted.
REQ-026 halt_id=1 in RUN or STEP_EXEC, with no branch_taken in the same cycle, -> DRAIN with the drain counter loaded to DRAIN_CYC-1.
REQ-027 halt_id in the same cycle as branch_taken SHALL be ignored, because the HALT is flushed.
REQ-028 DRAIN: pc_ena=0, ifid_ena=0, idex_ena=1, idex_flush=1, exmem_ena=1, memwb_ena=1; the counter decrements each cycle and the FSM moves to DONE when it reaches 0, giving exactly DRAIN_CYC cycles. The drain completes regardless of step_mode.
REQ-029 DONE: all ena 0, halted=1; remains until reset, and start is ignored.
REQ-030 cycle_count SHALL increment by 1 in every cycle spent in RUN, STEP_EXEC or DRAIN, wrapping modulo 2^32.
REQ-031 stall_count SHALL increment on each load-use stall cycle, saturating at 16'hFFFF.
REQ-032 Both counters SHALL hold their values in IDLE, STEP_WAIT and DONE.
REQ-033 All outputs other than the counters and halted SHALL be combinational from the current state and inputs; there is no added latency.
REQ-034 start, and step outside STEP_WAIT, SHALL be ignored.

Reset
REQ-035 While reset=0: state=IDLE, every ena=0, every flush=0, halted=0, cycle_count=0, stall_count=0, drain counter=0; these take effect immediately, without waiting for clk.
REQ-036 Reset asserted mid-DRAIN or mid-RUN SHALL abort to IDLE; after release the block stays in IDLE until the next start.

Verification
REQ-037 Reset release, start with step_mode=0, no hazards for 10 cycles -> all ena=1 and cycle_count=10.
REQ-038 RUN with idex_mem_read=1, idex_rt=5, ifid_rs=5 for 1 cycle -> pc_ena=0, ifid_ena=0, idex_flush=1, stall_count=1; the same inputs with idex_rt=0 -> no stall.
REQ-039 RUN with branch_taken=1 and the REQ-038 hazard in the same cycle -> ifid_flush=1, idex_flush=1, pc_ena=1, stall_count unchanged.
REQ-040 step_mode=1: start, then 3 step pulses spaced 5 cycles apart -> ena=1 in exactly 3 single cycles and cycle_count=3.
REQ-041 RUN with halt_id=1 pulse -> exactly 4 DRAIN cycles with pc_ena=0, then halted=1 and all ena=0; a subsequent start has no effect.
REQ-042 reset=0 asserted asynchronously in the middle of DRAIN -> outputs go to reset values before the next clk edge, and halted never rises.
